aes_inv_core: RTL

AES_INV_CORE -- requirements
Module: aes_inv_core

---
 rtl/aes_inv_core.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_core.sv
// AES-128 iterative decryption core: on-the-fly key expansion, then one inverse round per clock.
// Optional debug_state port is compiled in when AES_INV_DEBUG_EN is defined.
module aes_inv_core (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] cyphertext,
    output logic         done,
    output logic [127:0] plaintext
`ifdef AES_INV_DEBUG_EN
    ,
    output logic [3:0]   debug_state
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        KEXP   = 3'd2,
        WHITEN = 3'd3,
        ROUND  = 3'd4,
        FINAL  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   pt_q, pt_d;
    logic           done_q, done_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Key schedule: the same four S-boxes serve forward expansion and the inverse step.
    logic [31:0]  w0, w1, w2, w3, sub_in, sub_out, g_word, f0, f1, f2, f3;
    logic [3:0]   rcon_idx;
    logic [127:0] key_fwd, key_inv;

    assign {w0, w1, w2, w3} = key_q;
    assign sub_in   = (state_q == KEXP) ? w3 : (w3 ^ w2);
    assign rcon_idx = (state_q == KEXP) ? rnd_q : (rnd_q + 4'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ksub
            assign sub_out[31-8*gi -: 8] = sbox(sub_in[31-8*gi -: 8]);
        end
    endgenerate

    assign g_word  = {sub_out[23:0], sub_out[31:24]} ^ {rcon(rcon_idx), 24'h000000};
    assign f0      = w0 ^ g_word;
    assign f1      = w1 ^ f0;
    assign f2      = w2 ^ f1;
    assign f3      = w3 ^ f2;
    assign key_fwd = {f0, f1, f2, f3};
    assign key_inv = {w0 ^ g_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};

    // Data path: InvShiftRows + InvSubBytes, AddRoundKey, InvMixColumns.
    logic [127:0] isb, ark, mixed;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_isb
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = ROW + 4 * ((COL + 4 - ROW) % 4);
            assign isb[127-8*gi -: 8] = inv_sbox(blk_q[127-8*SRC -: 8]);
        end
    endgenerate

    assign ark = isb ^ key_inv;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_imix
            logic [7:0] a0, a1, a2, a3;
            assign a0 = ark[127-32*gi -: 8];
            assign a1 = ark[119-32*gi -: 8];
            assign a2 = ark[111-32*gi -: 8];
            assign a3 = ark[103-32*gi -: 8];
            assign mixed[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            assign mixed[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            assign mixed[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            assign mixed[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        blk_d   = blk_q;
        pt_d    = pt_q;
        if (load) begin
            state_d = LOAD;
            key_d   = key;
            blk_d   = cyphertext;
        end else begin
            case (state_q)
                LOAD: begin
                    state_d = KEXP;
                    rnd_d   = 4'd1;
                end
                KEXP: begin
                    key_d = key_fwd;
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == 4'd10) state_d = WHITEN;
                end
                WHITEN: begin
                    blk_d   = blk_q ^ key_q;
                    rnd_d   = 4'd9;
                    state_d = ROUND;
                end
                ROUND: begin
                    key_d = key_inv;
                    blk_d = mixed;
                    rnd_d = rnd_q - 4'd1;
                    if (rnd_q == 4'd1) state_d = FINAL;
                end
                FINAL: begin
                    pt_d    = ark;
                    state_d = DONE;
                end
                default: state_d = state_q;
            endcase
        end
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            key_q   <= 128'd0;
            blk_q   <= 128'd0;
            pt_q    <= 128'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
            blk_q   <= blk_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    assign done      = done_q;
    assign plaintext = pt_q;

`ifdef AES_INV_DEBUG_EN
    assign debug_state = {1'b0, state_q};
`endif

endmodule
